// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDrop
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// Fetch PC flop: synchronous reset to RESET_PC, loads d when load is high.
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, skid buffer for decode stalls,
// flush redirect. Define INSTR_MISALIGN_CHECK_EN to trap misaligned fetch PCs.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcIn,
  input  logic        stall,
  input  logic        flush,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic [31:0] pcAdd,
  output logic [31:0] instrOut,
  output logic [31:0] pcIdOut,
  output logic        instrValid,
  output logic        misalign
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc;
  logic         pc_load;
  logic [31:0]  skid_q, skid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_id_q, pc_id_d;
  logic         valid_q, valid_d;
  logic         deliver;
  logic [31:0]  deliver_word;
  logic         xfer;
  logic         bad_pc;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pcIn),
    .q   (pc)
  );

  assign pcAdd = pc + 32'd4;

`ifdef INSTR_MISALIGN_CHECK_EN
  // Misaligned PC parks the FSM in REQ with no request until a flush redirects it.
  assign bad_pc   = (state_q == StReq) && (pc[1:0] != 2'b00);
  assign misalign = !rst && bad_pc;
  assign imemAddr = pc;
`else
  assign bad_pc   = 1'b0;
  assign misalign = 1'b0;
  assign imemAddr = {pc[31:2], 2'b00};
`endif

  assign imemReq = !rst && (state_q == StReq) && !bad_pc;
  assign xfer    = imemReq && imemReady;

  always_comb begin
    state_d      = state_q;
    pc_load      = 1'b0;
    skid_d       = skid_q;
    deliver      = 1'b0;
    deliver_word = imemRdata;
    unique case (state_q)
      StReq: begin
        if (flush) begin
          pc_load = 1'b1;
          state_d = xfer ? StDrop : StReq;
        end else if (xfer) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (flush) begin
          pc_load = 1'b1;
          state_d = imemValid ? StReq : StDrop;
        end else if (imemValid) begin
          if (stall) begin
            skid_d  = imemRdata;
            state_d = StHold;
          end else begin
            deliver = 1'b1;
            pc_load = 1'b1;
            state_d = StReq;
          end
        end
      end
      StHold: begin
        if (flush) begin
          pc_load = 1'b1;
          state_d = StReq;
        end else if (!stall) begin
          deliver      = 1'b1;
          deliver_word = skid_q;
          pc_load      = 1'b1;
          state_d      = StReq;
        end
      end
      StDrop: begin
        if (flush) begin
          pc_load = 1'b1;
          state_d = StReq;
        end else if (imemValid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // IF/ID register: flush clears, stall freezes, otherwise valid only on delivery.
  always_comb begin
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (deliver) begin
      instr_d = deliver_word;
      pc_id_d = pc;
      valid_d = 1'b1;
    end else if (!stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      skid_q  <= 32'h0;
      instr_q <= INSTR_NOP;
      pc_id_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      valid_q <= valid_d;
    end
  end

  assign instrOut   = instr_q;
  assign pcIdOut    = pc_id_q;
  assign instrValid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch against a one-outstanding imem model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcIn;
  logic        stall;
  logic        flush;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic [31:0] pcAdd;
  logic [31:0] instrOut;
  logic [31:0] pcIdOut;
  logic        instrValid;
  logic        misalign;

  logic        sel;
  logic [31:0] pc_ovr;
  logic        ready_en;
  logic        resp_en;
  logic        ovr_en;
  logic [31:0] ovr_word;

  logic        pend      = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          xfer_cnt  = 0;
  int          x0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pcIn      = sel ? pc_ovr : pcAdd;
  assign imemReady = ready_en;
  assign imemValid = pend && resp_en;
  assign imemRdata = ovr_en ? ovr_word : (32'hCAFE_0000 ^ pend_addr);

  // Memory returns a word derived from the accepted address once resp_en allows it.
  always @(posedge clk) begin
    if (imemReq && imemReady) begin
      xfer_cnt  <= xfer_cnt + 1;
      pend      <= 1'b1;
      pend_addr <= imemAddr;
    end else if (pend && resp_en) begin
      pend <= 1'b0;
    end
  end

  instr_fetch #(
    .RESET_PC(32'h0000_1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pcIn      (pcIn),
    .stall     (stall),
    .flush     (flush),
    .imemReq   (imemReq),
    .imemAddr  (imemAddr),
    .imemReady (imemReady),
    .imemValid (imemValid),
    .imemRdata (imemRdata),
    .pcAdd     (pcAdd),
    .instrOut  (instrOut),
    .pcIdOut   (pcIdOut),
    .instrValid(instrValid),
    .misalign  (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; sel = 1'b0; pc_ovr = 32'h0;
    ready_en = 1'b1; resp_en = 1'b1; ovr_en = 1'b0; ovr_word = 32'h0;
    #1;
    check("req_during_rst0", {31'h0, imemReq}, 32'h0);
    step();
    check("rst_valid", {31'h0, instrValid}, 32'h0);
    check("rst_instr", instrOut, 32'h0000_0013);
    check("rst_pcid", pcIdOut, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    check("req_during_rst1", {31'h0, imemReq}, 32'h0);
    check("rst_pcadd", pcAdd, 32'h0000_1004);
    rst = 1'b0;
    #1;

    // Zero-wait streaming from RESET_PC.
    for (int k = 0; k < 3; k++) begin
      check("stream_req", {31'h0, imemReq}, 32'h1);
      check("stream_addr", imemAddr, 32'h0000_1000 + 32'(4 * k));
      step();
      check("stream_gap_valid", {31'h0, instrValid}, 32'h0);
      step();
      check("stream_valid", {31'h0, instrValid}, 32'h1);
      check("stream_pcid", pcIdOut, 32'h0000_1000 + 32'(4 * k));
      check("stream_instr", instrOut, 32'hCAFE_1000 + 32'(4 * k));
    end

    // Redirect to 0x2000 with imemReady low for 3 cycles.
    ready_en = 1'b0; flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_2000;
    x0 = xfer_cnt;
    step();
    flush = 1'b0; sel = 1'b0;
    check("flush_clears_valid", {31'h0, instrValid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("held_req", {31'h0, imemReq}, 32'h1);
      check("held_addr", imemAddr, 32'h0000_2000);
      if (i == 3) ready_en = 1'b1;
      step();
    end
    check("one_transfer", 32'(xfer_cnt - x0), 32'h1);
    check("wait_no_req", {31'h0, imemReq}, 32'h0);

    // Stall as DEADBEEF returns: skid into HOLD, outputs frozen.
    stall = 1'b1; ovr_en = 1'b1; ovr_word = 32'hDEAD_BEEF;
    step();
    check("hold_no_req", {31'h0, imemReq}, 32'h0);
    check("hold_instr_frozen", instrOut, 32'hCAFE_1008);
    check("hold_pcid_frozen", pcIdOut, 32'h0000_1008);
    check("hold_valid_frozen", {31'h0, instrValid}, 32'h0);
    step();
    check("hold2_no_req", {31'h0, imemReq}, 32'h0);
    check("hold2_instr", instrOut, 32'hCAFE_1008);
    stall = 1'b0; ovr_en = 1'b0;
    step();
    check("skid_instr", instrOut, 32'hDEAD_BEEF);
    check("skid_valid", {31'h0, instrValid}, 32'h1);
    check("skid_pcid", pcIdOut, 32'h0000_2000);
    check("skid_next_addr", imemAddr, 32'h0000_2004);

    // Stall holds a valid instruction while the next request goes out.
    stall = 1'b1;
    step();
    check("stall_keeps_valid", {31'h0, instrValid}, 32'h1);
    check("stall_keeps_instr", instrOut, 32'hDEAD_BEEF);
    stall = 1'b0;
    step();
    check("after_stall_instr", instrOut, 32'hCAFE_2004);
    check("after_stall_pcid", pcIdOut, 32'h0000_2004);
    check("after_stall_addr", imemAddr, 32'h0000_2008);

    // Flush in WAIT before the response: DROP, then discard the late word.
    resp_en = 1'b0;
    step();
    flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_0400;
    step();
    flush = 1'b0; sel = 1'b0; resp_en = 1'b1;
    check("drop_no_req", {31'h0, imemReq}, 32'h0);
    check("drop_valid", {31'h0, instrValid}, 32'h0);
    step();
    check("drop_discard_valid", {31'h0, instrValid}, 32'h0);
    check("drop_exit_req", {31'h0, imemReq}, 32'h1);
    check("drop_exit_addr", imemAddr, 32'h0000_0400);

    // Flush while the request is accepted: DROP.
    flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_0800;
    step();
    flush = 1'b0; sel = 1'b0;
    check("acc_flush_no_req", {31'h0, imemReq}, 32'h0);
    step();
    check("acc_flush_valid", {31'h0, instrValid}, 32'h0);
    check("acc_flush_addr", imemAddr, 32'h0000_0800);

    // Flush in WAIT coincident with the response: straight to REQ.
    step();
    flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_0C00;
    step();
    flush = 1'b0; sel = 1'b0;
    check("wait_flush_valid", {31'h0, instrValid}, 32'h0);
    check("wait_flush_req", {31'h0, imemReq}, 32'h1);
    check("wait_flush_addr", imemAddr, 32'h0000_0C00);

    // PC wrap and misaligned redirect.
    ready_en = 1'b0; flush = 1'b1; sel = 1'b1; pc_ovr = 32'hFFFF_FFFC;
    step();
    flush = 1'b0; sel = 1'b0;
    check("wrap_pcadd", pcAdd, 32'h0);
    check("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_0402;
    step();
    flush = 1'b0; sel = 1'b0;
`ifdef INSTR_MISALIGN_CHECK_EN
    check("mis_flag", {31'h0, misalign}, 32'h1);
    check("mis_no_req", {31'h0, imemReq}, 32'h0);
    ready_en = 1'b1;
    step();
    check("mis_flag_sticks", {31'h0, misalign}, 32'h1);
    check("mis_no_req2", {31'h0, imemReq}, 32'h0);
    check("mis_no_valid", {31'h0, instrValid}, 32'h0);
    ready_en = 1'b0;
`else
    check("mis_tied", {31'h0, misalign}, 32'h0);
    check("mis_addr_aligned", imemAddr, 32'h0000_0400);
    check("mis_req", {31'h0, imemReq}, 32'h1);
`endif
    flush = 1'b1; sel = 1'b1; pc_ovr = 32'h0000_3000;
    step();
    flush = 1'b0; sel = 1'b0;
    check("realign_misalign", {31'h0, misalign}, 32'h0);
    check("realign_addr", imemAddr, 32'h0000_3000);

    // Reset while in WAIT; the late response must be ignored.
    ready_en = 1'b1; resp_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rstw_valid", {31'h0, instrValid}, 32'h0);
    check("rstw_instr", instrOut, 32'h0000_0013);
    check("rstw_pcid", pcIdOut, 32'h0);
    check("rstw_misalign", {31'h0, misalign}, 32'h0);
    check("rstw_no_req", {31'h0, imemReq}, 32'h0);
    rst = 1'b0; resp_en = 1'b1;
    #1;
    check("rstw_addr", imemAddr, 32'h0000_1000);
    step();
    check("rstw_stale_ignored", {31'h0, instrValid}, 32'h0);
    step();
    check("rstw_fresh_valid", {31'h0, instrValid}, 32'h1);
    check("rstw_fresh_instr", instrOut, 32'hCAFE_1000);
    check("rstw_fresh_pcid", pcIdOut, 32'h0000_1000);

    // Reset while in HOLD, with stall still asserted.
    stall = 1'b1;
    step();
    step();
    check("rsth_hold_no_req", {31'h0, imemReq}, 32'h0);
    rst = 1'b1;
    step();
    check("rsth_valid", {31'h0, instrValid}, 32'h0);
    check("rsth_instr", instrOut, 32'h0000_0013);
    check("rsth_pcid", pcIdOut, 32'h0);
    check("rsth_no_req", {31'h0, imemReq}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    #1;
    check("rsth_addr", imemAddr, 32'h0000_1000);
    step();
    step();
    check("rsth_skid_dropped", instrOut, 32'hCAFE_1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
